seg_approx_adder_pipe: RTL and testbench

- Pipelined, parametrised successor to the segmented error-tolerant (type II) adder.
- Splits WIDTH-bit operands into SEGMENT_WIDTH segments.
- In approximate mode, each segment's carry-in is the carry-out its lower neighbour would produce with zero carry-in (carry chain cut at every segment boundary). In exact mode it is a full-carry adder.
- Two-stage registered datapath with valid/ready handshake and backpressure, for use inside streaming approximate-arithmetic datapaths.

---
 rtl/seg_approx_adder_pipe.sv | 149 ++++++++++++++
 tb/tb_seg_approx_adder_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_approx_adder_pipe.sv
// Two-stage segmented approximate/exact adder with valid/ready flow control.
// Define SEG_APPROX_ERR_MON_EN to add the exact-sum mismatch flag and saturating error counter.
module seg_approx_adder_pipe #(
  parameter int WIDTH         = 32,
  parameter int SEGMENT_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     add1_i,
  input  logic [WIDTH-1:0]     add2_i,
  input  logic                 carry_i,
  input  logic                 approx_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH:0]       result_o,
  output logic                 mismatch_o,
  output logic [CNT_WIDTH-1:0] err_count_o
);

  localparam int NSEG = WIDTH / SEGMENT_WIDTH;

  if (SEGMENT_WIDTH < 1 || SEGMENT_WIDTH > WIDTH || (WIDTH % SEGMENT_WIDTH) != 0) begin : g_bad_cfg
    $error("seg_approx_adder_pipe: WIDTH must be a positive multiple of SEGMENT_WIDTH");
  end

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic             r_s1_approx;
  logic [NSEG-1:0]  r_s1_g;
  logic [NSEG-1:0]  r_s1_p;

  logic             r_s2_valid;
  logic [WIDTH:0]   r_result;
  logic             r_mismatch;

  logic             w_s2_load;
  logic             w_s1_load;
  logic [NSEG-1:0]  w_g;
  logic [NSEG-1:0]  w_p;
  logic [NSEG:0]    w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout_top;
  logic [WIDTH:0]   w_result;

  assign w_s2_load = !r_s2_valid || ready_i;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign ready_o   = w_s1_load;
  assign valid_o   = r_s2_valid;
  assign result_o  = r_result;

  // Per-segment generate/propagate with zero carry-in, from the raw operands
  for (genvar k = 0; k < NSEG; k++) begin : g_gp
    logic [SEGMENT_WIDTH:0] w_seg;
    assign w_seg  = {1'b0, add1_i[k*SEGMENT_WIDTH +: SEGMENT_WIDTH]}
                  + {1'b0, add2_i[k*SEGMENT_WIDTH +: SEGMENT_WIDTH]};
    assign w_g[k] = w_seg[SEGMENT_WIDTH];
    assign w_p[k] = &w_seg[SEGMENT_WIDTH-1:0];
  end

  // Segment carry-ins; w_c[NSEG] is the full-lookahead carry-out used in exact mode
  always_comb begin
    w_c    = '0;
    w_c[0] = r_s1_cin;
    for (int k = 1; k <= NSEG; k++) begin
      if (k < NSEG && r_s1_approx)
        w_c[k] = r_s1_g[k-1];
      else
        w_c[k] = r_s1_g[k-1] | (r_s1_p[k-1] & w_c[k-1]);
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_sum
    if (k == NSEG - 1) begin : g_top
      logic [SEGMENT_WIDTH:0] w_top;
      assign w_top = {1'b0, r_s1_a[k*SEGMENT_WIDTH +: SEGMENT_WIDTH]}
                   + {1'b0, r_s1_b[k*SEGMENT_WIDTH +: SEGMENT_WIDTH]}
                   + (SEGMENT_WIDTH+1)'(w_c[k]);
      assign w_sum[k*SEGMENT_WIDTH +: SEGMENT_WIDTH] = w_top[SEGMENT_WIDTH-1:0];
      assign w_cout_top = w_top[SEGMENT_WIDTH];
    end else begin : g_low
      assign w_sum[k*SEGMENT_WIDTH +: SEGMENT_WIDTH] = r_s1_a[k*SEGMENT_WIDTH +: SEGMENT_WIDTH]
                                                     + r_s1_b[k*SEGMENT_WIDTH +: SEGMENT_WIDTH]
                                                     + SEGMENT_WIDTH'(w_c[k]);
    end
  end

  assign w_result = {(r_s1_approx ? w_cout_top : w_c[NSEG]), w_sum};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_cin    <= 1'b0;
      r_s1_approx <= 1'b0;
      r_s1_g      <= '0;
      r_s1_p      <= '0;
      r_s2_valid  <= 1'b0;
      r_result    <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= valid_i;
        if (valid_i) begin
          r_s1_a      <= add1_i;
          r_s1_b      <= add2_i;
          r_s1_cin    <= carry_i;
          r_s1_approx <= approx_i;
          r_s1_g      <= w_g;
          r_s1_p      <= w_p;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_result <= w_result;
      end
    end
  end

`ifdef SEG_APPROX_ERR_MON_EN
  logic [WIDTH:0]       w_exact;
  logic [CNT_WIDTH-1:0] r_err_count;

  assign w_exact = (WIDTH+1)'(r_s1_a) + (WIDTH+1)'(r_s1_b) + (WIDTH+1)'(r_s1_cin);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mismatch  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_s2_load && r_s1_valid) r_mismatch <= (w_result != w_exact);
      if (r_s2_valid && ready_i && r_mismatch && r_err_count != '1)
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign mismatch_o  = r_mismatch;
  assign err_count_o = r_err_count;
`else
  assign r_mismatch  = 1'b0;
  assign mismatch_o  = r_mismatch;
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_seg_approx_adder_pipe.sv
// Scoreboard bench for seg_approx_adder_pipe: randomized and directed stimulus vs. an arithmetic model.
module tb_seg_approx_adder_pipe;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam int CW = 16;
  localparam int NS = W / SW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  add1_i;
  logic [W-1:0]  add2_i;
  logic          carry_i;
  logic          approx_i;
  logic          valid_o;
  logic          ready_i;
  logic [W:0]    result_o;
  logic          mismatch_o;
  logic [CW-1:0] err_count_o;

  seg_approx_adder_pipe #(.WIDTH(W), .SEGMENT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .carry_i(carry_i), .approx_i(approx_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .mismatch_o(mismatch_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W:0] res;
    logic       mm;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          hold = 1'b0;
  logic [W:0]    hold_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Exact mode is a plain add; approx mode rebuilds each segment with the
  // carry its lower neighbour produces from a zero carry-in.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic ap);
    logic [W:0] r;
    int sa, sb, s, cin;
    if (!ap) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r   = '0;
    cin = int'(c);
    for (int k = 0; k < NS; k++) begin
      sa = int'((a >> (k*SW)) & ((1 << SW) - 1));
      sb = int'((b >> (k*SW)) & ((1 << SW) - 1));
      s  = sa + sb + cin;
      r[k*SW +: SW] = SW'(s);
      if (k == NS - 1) r[W] = (s >= (1 << SW));
      cin = ((sa + sb) >= (1 << SW)) ? 1 : 0;
    end
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic ap, input logic v, input logic r, output logic acc);
    exp_t e;
    @(negedge clk_i);
    add1_i = a; add2_i = b; carry_i = c; approx_i = ap; valid_i = v; ready_i = r;
    #1;
    chk("ready_o", {63'd0, ready_o}, {63'd0, (q.size() < 2) || r});
    acc = v && ready_o;
    if (acc) begin
      e.res = model(a, b, c, ap);
`ifdef SEG_APPROX_ERR_MON_EN
      e.mm  = (e.res != model(a, b, c, 1'b0));
`else
      e.mm  = 1'b0;
`endif
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic r);
    logic acc;
    drive('0, '0, 1'b0, 1'b0, 1'b0, r, acc);
  endtask

  // Monitor: compares every emitted result and checks stability under backpressure
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        hold = 1'b0;
        continue;
      end
`ifdef SEG_APPROX_ERR_MON_EN
      chk("err_count", {48'd0, err_count_o}, {48'd0, exp_cnt});
`endif
      if (hold) begin
        chk("hold_valid", {63'd0, valid_o}, 64'd1);
        chk("hold_result", {31'd0, result_o}, {31'd0, hold_res});
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output actual=%h required=none", result_o);
        end else begin
          e = q.pop_front();
          chk("result", {31'd0, result_o}, {31'd0, e.res});
          chk("mismatch", {63'd0, mismatch_o}, {63'd0, e.mm});
          if (e.mm && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
      end
      hold     = valid_o && !ready_i;
      hold_res = result_o;
    end
  end

  initial begin
    logic acc;
    logic [W-1:0] a, b;
    logic bp_drop;
    int sent, cyc;
    rst_i = 1'b1; valid_i = 1'b0; add1_i = '0; add2_i = '0;
    carry_i = 1'b0; approx_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("rst_result_o", {31'd0, result_o}, 64'd0);
    chk("rst_mismatch_o", {63'd0, mismatch_o}, 64'd0);
    chk("rst_err_count_o", {48'd0, err_count_o}, 64'd0);
    chk("rst_ready_o", {63'd0, ready_o}, 64'd1);

    // Single accept and two-cycle latency
    drive(32'h0000000F, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    chk("accept1", {63'd0, acc}, 64'd1);
    idle(1'b1);
    chk("latency_cycle1_valid", {63'd0, valid_o}, 64'd0);
    idle(1'b1);
    chk("latency_cycle2_valid", {63'd0, valid_o}, 64'd1);
    chk("latency_result", {31'd0, result_o}, {31'd0, 33'h0_00000010});

    // Broken carry chain, then the same operands exact, then top carry-out
    drive(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    drive(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    drive(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    repeat (4) idle(1'b1);

    // Backpressure: 4 transactions, ready_i low for 3 cycles mid-stream
    sent = 0; bp_drop = 1'b0;
    for (cyc = 0; cyc < 30 && (sent < 4 || q.size() > 0); cyc++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            sent < 4, !(cyc >= 1 && cyc <= 3), acc);
      if (!ready_o) bp_drop = 1'b1;
      if (acc) sent++;
    end
    chk("bp_ready_dropped", {63'd0, bp_drop}, 64'd1);
    chk("bp_all_sent", sent, 4);

    // Full rate with approx toggling every cycle
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? ~a : $urandom;
      drive(a, b, 1'($urandom_range(0, 1)), 1'(i % 2), 1'b1, 1'b1, acc);
      if (!acc) begin
        total++; bad++;
        $display("FAIL fullrate_accept actual=0 required=1");
      end
    end
    repeat (3) idle(1'b1);

    // Reset with both stages full
    drive(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    drive(32'h00000FFF, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    drive(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    q.delete();
    exp_cnt = '0;
    @(negedge clk_i);
    rst_i = 1'b0; ready_i = 1'b1;
    #1;
    chk("midrst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("midrst_err_count_o", {48'd0, err_count_o}, 64'd0);
    chk("midrst_ready_o", {63'd0, ready_o}, 64'd1);
    drive(32'h0000000F, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    repeat (3) idle(1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? ~a : $urandom;
      drive(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, acc);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", q.size(), 0);
    idle(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
